// File: rtl/fp_norm_lshift.sv
// Iterative left-shift normalizer: shifts the mantissa one bit per clock toward
// the leading-one position, decrementing the exponent, with valid/ready handshakes.
module fp_norm_lshift #(
  parameter int nBit = 22,
  parameter int eBit = 7,
  parameter int cBit = 4
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iValid,
  output logic            oReady,
  input  logic            iSign,
  input  logic [eBit:0]   iExp,
  input  logic [nBit+1:0] iMant,
  output logic            oValid,
  input  logic            iReady,
  output logic            oSign,
  output logic [eBit:0]   oExp,
  output logic [nBit:0]   oMant,
  output logic [cBit:0]   oShift,
  output logic            oZero,
  output logic            oUnderflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic [eBit:0]     exp_q, exp_d;
  logic [nBit+1:0]   mant_q, mant_d;
  logic [cBit:0]     cnt_q, cnt_d;
  logic              zero_q, zero_d;
  logic              unf_q, unf_d;

  logic mant_is_zero, mant_norm, exp_floor;
  assign mant_is_zero = (mant_q == '0);
  assign mant_norm    = mant_q[nBit+1];
  // Stop shifting once exp reaches 1: one more step would leave no room for exp 0.
  assign exp_floor    = (exp_q <= (eBit+1)'(1));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (iValid) state_d = SHIFT;
      SHIFT: if (mant_is_zero || mant_norm || exp_floor) state_d = DONE;
      DONE:  if (iReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sign_d = sign_q;
    exp_d  = exp_q;
    mant_d = mant_q;
    cnt_d  = cnt_q;
    zero_d = zero_q;
    unf_d  = unf_q;
    case (state_q)
      IDLE: begin
        if (iValid) begin
          sign_d = iSign;
          exp_d  = iExp;
          mant_d = iMant;
          cnt_d  = '0;
          zero_d = 1'b0;
          unf_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (mant_is_zero) begin
          exp_d  = '0;
          zero_d = 1'b1;
        end else if (mant_norm) begin
          exp_d  = exp_q;
        end else if (exp_floor) begin
          exp_d  = '0;
          unf_d  = 1'b1;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - (eBit+1)'(1);
          cnt_d  = cnt_q + (cBit+1)'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    oReady     = (state_q == IDLE) && !iRst;
    oValid     = (state_q == DONE);
    oSign      = sign_q;
    oExp       = exp_q;
    oMant      = mant_q[nBit:0];
    oShift     = cnt_q;
    oZero      = zero_q;
    oUnderflow = unf_q;
  end

endmodule

// File: tb/tb_fp_norm_lshift.sv
// Directed + random checks of fp_norm_lshift against an independent
// leading-zero model, with a queue scoreboard and latency measurement.
module tb_fp_norm_lshift;

  logic        iClk = 1'b0;
  logic        iRst = 1'b0;
  logic        iValid = 1'b0;
  logic        oReady;
  logic        iSign = 1'b0;
  logic [7:0]  iExp = '0;
  logic [23:0] iMant = '0;
  logic        oValid;
  logic        iReady = 1'b0;
  logic        oSign;
  logic [7:0]  oExp;
  logic [22:0] oMant;
  logic [4:0]  oShift;
  logic        oZero;
  logic        oUnderflow;

  fp_norm_lshift #(.nBit(22), .eBit(7), .cBit(4)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
    .iSign(iSign), .iExp(iExp), .iMant(iMant), .oValid(oValid),
    .iReady(iReady), .oSign(oSign), .oExp(oExp), .oMant(oMant),
    .oShift(oShift), .oZero(oZero), .oUnderflow(oUnderflow)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
    logic [4:0]  shift;
    logic        zero;
    logic        unf;
    int          lat;
  } res_t;

  res_t sb[$];
  res_t last;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: count leading zeros, limited by how far the exponent can drop before 1.
  function automatic res_t model(input logic s, input logic [7:0] e, input logic [23:0] m);
    res_t r;
    int lz, maxs, sh;
    logic found;
    logic [23:0] shifted;
    r.sign = s; r.zero = 1'b0; r.unf = 1'b0;
    if (m == 24'd0) begin
      r.exp = '0; r.mant = '0; r.shift = '0; r.zero = 1'b1; r.lat = 2;
      return r;
    end
    lz = 0; found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && m[i]) begin
        lz = 23 - i;
        found = 1'b1;
      end
    end
    maxs = (e == 8'd0) ? 0 : int'(e) - 1;
    if (lz <= maxs) begin
      sh = lz;
      r.exp = 8'(int'(e) - lz);
    end else begin
      sh = maxs;
      r.exp = '0;
      r.unf = 1'b1;
    end
    shifted = m << sh;
    r.mant  = shifted[22:0];
    r.shift = 5'(sh);
    r.lat   = sh + 2;
    return r;
  endfunction

  task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m);
    @(negedge iClk);
    chk("ready_before_accept", oReady, 1);
    iSign = s; iExp = e; iMant = m; iValid = 1'b1;
    sb.push_back(model(s, e, m));
    @(posedge iClk);
    #1 iValid = 1'b0;
  endtask

  // Called #1 after the accept edge; counts edges until oValid.
  task automatic collect();
    int edges;
    edges = 1;
    while (!oValid && edges < 60) begin
      @(posedge iClk);
      #1;
      edges++;
    end
    chk("valid_seen", oValid, 1);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      last = sb.pop_front();
      chk("latency", edges, last.lat);
      chk("sign", oSign, last.sign);
      chk("exp", oExp, last.exp);
      chk("mant", oMant, last.mant);
      chk("shift", oShift, last.shift);
      chk("zero", oZero, last.zero);
      chk("underflow", oUnderflow, last.unf);
    end
  endtask

  task automatic release_result();
    @(negedge iClk);
    iReady = 1'b1;
    @(posedge iClk);
    #1 iReady = 1'b0;
    chk("valid_drop", oValid, 0);
    chk("ready_back", oReady, 1);
  endtask

  initial begin
    #2 iRst = 1'b1;
    #1;
    chk("rst_ready", oReady, 0);
    chk("rst_valid", oValid, 0);
    chk("rst_outs", {oSign, oExp, oMant, oShift, oZero, oUnderflow}, 0);
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    #1 chk("idle_ready", oReady, 1);

    send(1'b1, 8'd127, 24'h800000); collect(); release_result();
    send(1'b0, 8'd100, 24'h000001); collect(); release_result();
    send(1'b0, 8'd3,   24'h000100); collect(); release_result();
    send(1'b0, 8'd50,  24'h000000); collect(); release_result();
    send(1'b0, 8'd0,   24'h000100); collect(); release_result();
    send(1'b1, 8'd0,   24'h900000); collect(); release_result();
    send(1'b0, 8'd1,   24'h400000); collect(); release_result();

    // Backpressure: result held, iValid pulse ignored.
    send(1'b1, 8'd127, 24'h800000); collect();
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk);
      iValid = (i == 2);
      iMant  = 24'h000001;
      chk("bp_valid", oValid, 1);
      chk("bp_ready", oReady, 0);
      chk("bp_outs", {oSign, oExp, oMant, oShift, oZero, oUnderflow},
          {last.sign, last.exp, last.mant, last.shift, last.zero, last.unf});
    end
    @(negedge iClk);
    iValid = 1'b0;
    chk("bp_hold_after_pulse", oValid, 1);
    release_result();

    // iReady and iValid together in DONE: operand taken one cycle later.
    send(1'b0, 8'd20, 24'h001234); collect();
    @(negedge iClk);
    iReady = 1'b1; iValid = 1'b1;
    iSign = 1'b0; iExp = 8'd50; iMant = 24'h000000;
    sb.push_back(model(1'b0, 8'd50, 24'h000000));
    @(posedge iClk);
    #1 iReady = 1'b0;
    chk("overlap_not_taken", oReady, 1);
    chk("overlap_valid_low", oValid, 0);
    @(posedge iClk);
    #1 iValid = 1'b0;
    collect(); release_result();

    for (int n = 0; n < 12; n++) begin
      logic [31:0] r;
      r = $urandom >> $urandom_range(8, 31);
      send(1'($urandom), 8'($urandom_range(0, 255)), r[23:0]);
      collect(); release_result();
    end

    // Asynchronous reset in the 10th SHIFT cycle.
    send(1'b0, 8'd100, 24'h000001);
    repeat (9) @(posedge iClk);
    #2;
    chk("pre_rst_shift", oShift, 9);
    iRst = 1'b1;
    #1;
    chk("mid_rst_valid", oValid, 0);
    chk("mid_rst_shift", oShift, 0);
    chk("mid_rst_ready", oReady, 0);
    chk("mid_rst_exp_mant", {oExp, oMant}, 0);
    sb.delete();
    @(negedge iClk);
    iRst = 1'b0;
    send(1'b1, 8'd127, 24'h800000); collect(); release_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
